sf_pkt_fifo: RTL and testbench
==============================

// Module: sf_pkt_fifo
// PURPOSE
//  Packet-mode store-and-forward FIFO with valid/ready handshakes on both sides. A packet
//  becomes visible to the reader only after its eop beat is written without error.
//  Errored, aborted and oversize packets are discarded in place and counted.
//  Sits between a packet source (e.g. MAC RX) and a consumer that must never see partial packets.
// PARAMETERS
//  DEPTH_LG2   4   log2 of entry count; DEPTH = 1<<DEPTH_LG2 beats.
//  DATA_WIDTH  32  payload bits per beat; each memory entry also stores 1 eop bit.
//  CNT_WIDTH   16  width of the saturating drop counter.
// PORTS
//  clk         in   1              clock; all state updates on posedge.
//  rst_n       in   1              async assert, active-low reset; deassert is sync to clk.
//  wvalid_i    in   1              write beat valid.
//  wready_o    out  1              write beat accepted when wvalid_i & wready_o.
//  wdata_i     in   DATA_WIDTH     write payload.
//  sop_i       in   1              first beat of a packet.
//  eop_i       in   1              last beat of a packet.
//  err_i       in   1              packet error; sampled only on the eop beat.
//  rvalid_o    out  1              committed beat available at head.
//  rready_i    in   1              read beat consumed when rvalid_o & rready_i.
//  rdata_o     out  DATA_WIDTH     head payload; combinational from memory; valid only with rvalid_o.
//  reop_o      out  1              head beat is a packet's last beat.
//  pkt_cnt_o   out  DEPTH_LG2+1    committed packets not yet fully read.
//  drop_cnt_o  out  CNT_WIDTH      dropped packets; saturates at all-ones.
// BEHAVIOUR
//  Pointers (DEPTH_LG2+1 bits, wrap bit on MSB):
//   wrptr = commit ptr; wrptr_tmp = speculative write ptr; rdptr = read ptr.
//   Memory is written at wrptr_tmp[DEPTH_LG2-1:0].
//  Reset: state=IDLE; all pointers 0; pkt_cnt_o=0; drop_cnt_o=0.
//   Outputs after reset: rvalid_o=0, wready_o=1. Memory is not reset.
//   Reset mid-packet discards the partial packet and any committed data.
//  rvalid_o = (rdptr != wrptr). A read advances rdptr by 1.
//  wready_o = 1 in DROP; otherwise (wrptr_tmp - rdptr) != DEPTH.
//  FSM, evaluated on each accepted write beat:
//   IDLE: any beat starts a packet, whether or not sop_i is set.
//    eop&!err: write beat, commit (wrptr_n = wrptr_tmp+1) -> IDLE.
//    eop&err: no commit, wrptr_tmp rewinds to wrptr, drop++ -> IDLE.
//    !eop: write beat, wrptr_tmp+1 -> PKT.
//   PKT:
//    sop_i: abort. Rewind wrptr_tmp to wrptr, drop++, then handle this beat as in IDLE, same cycle.
//    eop: commit or drop as in IDLE -> IDLE.
//    !eop, new partial length (wrptr_tmp_n - wrptr) == DEPTH: packet can never fit.
//     Rewind, drop++ -> DROP.
//   DROP: beats are accepted and not written. eop -> IDLE.
//    A sop&!eop beat -> PKT, written as a new start. A sop&eop beat is handled as in IDLE.
//  A packet of exactly DEPTH beats is legal and commits.
//  Latency: a committed packet's first beat is readable (rvalid_o=1) one cycle after the eop write edge.
//  pkt_cnt_o: +1 on commit, -1 on a read with reop_o=1. Both in one cycle -> unchanged.
//  Same-cycle write and read is allowed. wready_o uses registered pointers (no read-to-write bypass).
//  Rewind never moves wrptr_tmp below wrptr. rdptr never passes wrptr.
//  Sim-only checks: $error on a write while !wready_o. $error on a read while !rvalid_o.
// TESTING (DEPTH_LG2=2, DEPTH=4)
//  1. 3-beat packet A,B,C with eop on C, err=0.
//     rvalid_o rises 1 cycle after C. Reads give A,B,C with reop on C. pkt_cnt_o 1 -> 0.
//  2. 2-beat packet with err=1 on eop.
//     rvalid_o stays 0; drop_cnt_o=1. Next good 1-beat packet D reads back D.
//  3. 6-beat packet, no reads.
//     After beat 4 -> DROP; beats 5-6 accepted and discarded; drop_cnt_o=1.
//     Then a 4-beat packet commits and reads back intact.
//  4. sop_i on beat 3 of an open packet.
//     First packet dropped (drop_cnt_o=1). New packet from beat 3 commits normally.
//  5. Fill with 1-beat packets P0..P3; then write P4 while reading P0 in the same cycle.
//     wready_o=0 that cycle; P4 accepted the next cycle.
//     pkt_cnt_o goes 4 -> 3 -> 4; wrap bit toggles correctly.
//  6. Assert rst_n=0 asynchronously mid-packet, with one packet committed.
//     Immediately: rvalid_o=0, pkt_cnt_o=0, drop_cnt_o=0, wready_o=1.

Source files
------------

// File: rtl/sf_pkt_fifo.sv
// sf_pkt_fifo: packet-mode store-and-forward FIFO; packets become readable only after a clean eop,
// errored/aborted/oversize packets are rewound in place and counted.
module sf_pkt_fifo #(
  parameter int DEPTH_LG2  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wvalid_i,
  output logic                  wready_o,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  sop_i,
  input  logic                  eop_i,
  input  logic                  err_i,
  output logic                  rvalid_o,
  input  logic                  rready_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  reop_o,
  output logic [DEPTH_LG2:0]    pkt_cnt_o,
  output logic [CNT_WIDTH-1:0]  drop_cnt_o
);
  localparam int PW = DEPTH_LG2 + 1;
  localparam logic [PW-1:0] FULL = PW'(1 << DEPTH_LG2);
  localparam logic [PW-1:0] ONE = PW'(1);
  typedef enum logic [1:0] {IDLE, PKT, DROP} state_t;
  state_t state, state_n;
  logic [PW-1:0] wrptr, wrptr_tmp, rdptr, wrptr_n, wrptr_tmp_n, base, base_inc;
  logic [DATA_WIDTH:0] mem [1 << DEPTH_LG2];
  logic wr, rd, skip, abort, commit, fail_err, oversize;
  logic [1:0] drop_inc;
  logic [CNT_WIDTH:0] drop_sum;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // an abort rewinds to the commit pointer first, then the beat is handled as a fresh start
  always_comb begin
    skip = state == DROP && !sop_i;
    abort = state == PKT && sop_i;
    base = abort ? wrptr : wrptr_tmp;
    base_inc = base + ONE;
    commit = wr && !skip && eop_i && !err_i;
    fail_err = wr && !skip && eop_i && err_i;
    oversize = wr && !skip && !eop_i && (base_inc - wrptr) == FULL;
    drop_inc = {1'b0, wr && abort} + {1'b0, fail_err || oversize};
    drop_sum = {1'b0, drop_cnt_o} + (CNT_WIDTH + 1)'(drop_inc);
    wrptr_n = commit ? base_inc : wrptr;
    wrptr_tmp_n = (!wr || skip) ? wrptr_tmp : (fail_err || oversize) ? wrptr : base_inc;
    state_n = !wr ? state : eop_i ? IDLE : (skip || oversize) ? DROP : PKT;
  end
  always_comb begin
    wready_o = state == DROP || (wrptr_tmp - rdptr) != FULL;
    rvalid_o = rdptr != wrptr;
    {reop_o, rdata_o} = mem[rdptr[DEPTH_LG2-1:0]];
    wr = wvalid_i && wready_o;
    rd = rvalid_o && rready_i;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wrptr <= '0;
      wrptr_tmp <= '0;
      rdptr <= '0;
      pkt_cnt_o <= '0;
      drop_cnt_o <= '0;
    end else begin
      wrptr <= wrptr_n;
      wrptr_tmp <= wrptr_tmp_n;
      rdptr <= rd ? rdptr + ONE : rdptr;
      pkt_cnt_o <= (commit && !(rd && reop_o)) ? pkt_cnt_o + ONE :
                   (!commit && rd && reop_o) ? pkt_cnt_o - ONE : pkt_cnt_o;
      drop_cnt_o <= drop_sum[CNT_WIDTH] ? '1 : drop_sum[CNT_WIDTH-1:0];
    end
  always_ff @(posedge clk)
    if (wr && !skip) mem[base[DEPTH_LG2-1:0]] <= {eop_i, wdata_i};
  always_ff @(posedge clk)
    if (rst_n) begin
      assert (!(wvalid_i && !wready_o)) else $error("sf_pkt_fifo: write while not ready");
      assert (!(rready_i && !rvalid_o)) else $error("sf_pkt_fifo: read while not valid");
    end
endmodule

// File: tb/tb_sf_pkt_fifo.sv
// tb_sf_pkt_fifo: directed scenarios plus random traffic, checked every cycle against a
// queue-based packet model (committed beats, open packet, drop flag).
module tb_sf_pkt_fifo;
  localparam int LG = 2, DEPTH = 4, DW = 32, CW = 3;
  logic clk = 0, rst_n = 1, wvalid = 0, wready, sop = 0, eop = 0, err = 0;
  logic rvalid, rready = 0, reop;
  logic [DW-1:0] wdata = '0, rdata;
  logic [LG:0] pkt_cnt;
  logic [CW-1:0] drop_cnt;
  logic [DW:0] cq[$], pq[$];
  bit dropping;
  int drops, cmp_n = 0, fail_n = 0;
  bit acc;
  always #5 clk = ~clk;
  sf_pkt_fifo #(.DEPTH_LG2(LG), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .wvalid_i(wvalid), .wready_o(wready), .wdata_i(wdata),
    .sop_i(sop), .eop_i(eop), .err_i(err), .rvalid_o(rvalid), .rready_i(rready),
    .rdata_o(rdata), .reop_o(reop), .pkt_cnt_o(pkt_cnt), .drop_cnt_o(drop_cnt));
  function automatic bit m_wready();
    return dropping || (cq.size() + pq.size() != DEPTH);
  endfunction
  function automatic int m_pkts();
    int n = 0;
    foreach (cq[i]) n += int'(cq[i][DW]);
    return n;
  endfunction
  function automatic void m_drop();
    if (drops < (1 << CW) - 1) drops++;
  endfunction
  function automatic void m_reset();
    cq.delete();
    pq.delete();
    dropping = 0;
    drops = 0;
  endfunction
  function automatic void m_write(input logic [DW-1:0] d, input bit s, input bit e, input bit er);
    if (dropping && !s) begin
      if (e) dropping = 0;
      return;
    end
    dropping = 0;
    if (s && pq.size() > 0) begin
      m_drop();
      pq.delete();
    end
    pq.push_back({e, d});
    if (e) begin
      if (er) m_drop();
      else foreach (pq[i]) cq.push_back(pq[i]);
      pq.delete();
    end else if (pq.size() == DEPTH) begin
      m_drop();
      pq.delete();
      dropping = 1;
    end
  endfunction
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp_n++;
    assert (obs === exp) else begin
      fail_n++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic compare_all();
    check("wready", wready, m_wready());
    check("rvalid", rvalid, cq.size() > 0);
    if (cq.size() > 0) begin
      check("rdata", rdata, cq[0][DW-1:0]);
      check("reop", reop, cq[0][DW]);
    end
    check("pkt_cnt", pkt_cnt, m_pkts());
    check("drop_cnt", drop_cnt, drops);
  endtask
  task automatic step(input bit wv, input logic [DW-1:0] d, input bit s, input bit e, input bit er,
                      input bit rr, output bit accepted);
    bit w, r;
    w = wv && m_wready();
    r = rr && cq.size() > 0;
    wvalid = w; wdata = d; sop = s; eop = e; err = er; rready = r;
    @(posedge clk);
    if (r) void'(cq.pop_front());
    if (w) m_write(d, s, e, er);
    accepted = w;
    #1;
    wvalid = 0; rready = 0; sop = 0; eop = 0; err = 0;
    compare_all();
  endtask
  task automatic put(input logic [DW-1:0] d, input bit s, input bit e, input bit er);
    bit a = 0;
    for (int i = 0; i < 8 && !a; i++) step(1, d, s, e, er, 0, a);
    check("put_accept", a, 1);
  endtask
  task automatic get();
    bit a;
    step(0, '0, 0, 0, 0, 1, a);
  endtask
  task automatic do_reset();
    rst_n = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    m_reset();
    compare_all();
  endtask
  initial begin
    m_reset();
    #1 rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_wready", wready, 1);
    check("rst_rvalid", rvalid, 0);
    check("rst_pkt_cnt", pkt_cnt, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    rst_n = 1;
    // 1: good 3-beat packet
    put(32'hA, 1, 0, 0);
    put(32'hB, 0, 0, 0);
    check("t1_rvalid_pre", rvalid, 0);
    put(32'hC, 0, 1, 0);
    check("t1_rvalid", rvalid, 1);
    check("t1_pkt", pkt_cnt, 1);
    check("t1_rdata_a", rdata, 32'hA);
    repeat (2) get();
    check("t1_reop_c", reop, 1);
    get();
    check("t1_pkt_done", pkt_cnt, 0);
    // 2: errored packet then good single beat
    do_reset();
    put(32'h11, 1, 0, 0);
    put(32'h12, 0, 1, 1);
    check("t2_rvalid", rvalid, 0);
    check("t2_drop", drop_cnt, 1);
    put(32'hD, 1, 1, 0);
    check("t2_rdata_d", rdata, 32'hD);
    get();
    // 3: oversize packet then exactly-DEPTH packet
    do_reset();
    for (int i = 0; i < 6; i++) begin
      put(32'h30 + i, i == 0, i == 5, 0);
      if (i == 3) check("t3_drop_b4", drop_cnt, 1);
    end
    check("t3_rvalid", rvalid, 0);
    for (int i = 0; i < 4; i++) put(32'h40 + i, i == 0, i == 3, 0);
    check("t3_pkt", pkt_cnt, 1);
    check("t3_full", wready, 0);
    repeat (4) get();
    check("t3_drop", drop_cnt, 1);
    // 4: sop on beat 3 aborts the open packet
    do_reset();
    put(32'h51, 1, 0, 0);
    put(32'h52, 0, 0, 0);
    put(32'h61, 1, 0, 0);
    check("t4_drop", drop_cnt, 1);
    put(32'h62, 0, 1, 0);
    check("t4_head", rdata, 32'h61);
    repeat (2) get();
    check("t4_pkt", pkt_cnt, 0);
    // 5: full, blocked write during read, then wrap
    do_reset();
    for (int i = 0; i < 4; i++) put(32'h70 + i, 1, 1, 0);
    check("t5_pkt4", pkt_cnt, 4);
    check("t5_wready0", wready, 0);
    step(1, 32'h74, 1, 1, 0, 1, acc);
    check("t5_pkt3", pkt_cnt, 3);
    check("t5_wready1", wready, 1);
    put(32'h74, 1, 1, 0);
    check("t5_pkt4b", pkt_cnt, 4);
    repeat (4) get();
    check("t5_empty", rvalid, 0);
    // 6: async reset mid-packet with a committed packet present
    do_reset();
    put(32'h81, 1, 1, 0);
    put(32'h82, 1, 0, 0);
    put(32'h83, 0, 0, 0);
    #2 rst_n = 0;
    #1;
    check("t6_rvalid", rvalid, 0);
    check("t6_pkt", pkt_cnt, 0);
    check("t6_drop", drop_cnt, 0);
    check("t6_wready", wready, 1);
    m_reset();
    @(posedge clk);
    #1 rst_n = 1;
    compare_all();
    // random traffic; drop counter is narrow so saturation is reached
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 5) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0, acc);
    check("sat_drop", drop_cnt, drops);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
    $finish;
  end
endmodule
